// File: rtl/calculator_pkg.sv
// Shared widths and FSM state encoding for the calculator controller.
package calculator_pkg;

  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    ADD   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/calc_controller.sv
// Sequencer that reads operand words, feeds the adder two halves at a time and writes results.
// Define CALC_CTRL_CNT_EN to add the word_cnt_o output-word counter.
module calc_controller
  import calculator_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr_i,
  input  logic [ADDR_W-1:0]        read_end_addr_i,
  input  logic [ADDR_W-1:0]        write_start_addr_i,
  input  logic [ADDR_W-1:0]        write_end_addr_i,
  output logic                     mem_re_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  output logic                     loc_sel_o,
  input  logic [MEM_WORD_SIZE-1:0] buffer_i,
  output logic                     busy_o,
`ifdef CALC_CTRL_CNT_EN
  output logic [ADDR_W:0]          word_cnt_o,
`endif
  output logic                     done_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_end_q, rd_end_d;
  logic [ADDR_W-1:0]   wr_end_q, wr_end_d;
  logic                half_q, half_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_end_d  = rd_end_q;
    wr_end_d  = wr_end_q;
    half_d    = half_q;
    rd_last_d = rd_last_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rd_ptr_d  = read_start_addr_i;
          wr_ptr_d  = write_start_addr_i;
          rd_end_d  = read_end_addr_i;
          wr_end_d  = write_end_addr_i;
          half_d    = 1'b0;
          rd_last_d = 1'b0;
          if ((read_start_addr_i > read_end_addr_i) ||
              (write_start_addr_i > write_end_addr_i)) begin
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end
      end
      // Once the end address has been read the pointer parks there, so an odd
      // operand count re-reads the last word for the upper half.
      READ: begin
        if (rd_ptr_q == rd_end_q) begin
          rd_last_d = 1'b1;
        end else begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        state_d = LATCH;
      end
      LATCH: begin
        op_a_d  = mem_rdata_i[DATA_W-1:0];
        op_b_d  = mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
        state_d = ADD;
      end
      ADD: begin
        half_d  = ~half_q;
        state_d = half_q ? WRITE : READ;
      end
      WRITE: begin
        if (rd_last_q || (wr_ptr_q == wr_end_q)) begin
          state_d = DONE;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          state_d  = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_end_q  <= '0;
      wr_end_q  <= '0;
      half_q    <= 1'b0;
      rd_last_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_end_q  <= rd_end_d;
      wr_end_q  <= wr_end_d;
      half_q    <= half_d;
      rd_last_q <= rd_last_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  // Strobes decode straight from the state register so reset removes them at once.
  assign mem_re_o    = (state_q == READ);
  assign mem_we_o    = (state_q == WRITE);
  assign mem_addr_o  = mem_re_o ? rd_ptr_q : (mem_we_o ? wr_ptr_q : '0);
  assign mem_wdata_o = mem_we_o ? buffer_i : '0;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign loc_sel_o   = half_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

`ifdef CALC_CTRL_CNT_EN
  localparam int CNT_W = ADDR_W + 1;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if ((state_q == IDLE) && start_i) begin
      word_cnt_d = '0;
    end else if (state_q == WRITE) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: memory/adder/buffer environment plus a job-level reference model.
// Define CALC_CTRL_CNT_EN to also check the optional word counter.
module tb_calc_controller;
  import calculator_pkg::*;

  localparam int ADDR_W = 10;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     start_i;
  logic [ADDR_W-1:0]        read_start_addr_i, read_end_addr_i;
  logic [ADDR_W-1:0]        write_start_addr_i, write_end_addr_i;
  logic                     mem_re_o, mem_we_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [MEM_WORD_SIZE-1:0] mem_rdata_i;
  logic [MEM_WORD_SIZE-1:0] mem_wdata_o;
  logic [DATA_W-1:0]        op_a_o, op_b_o;
  logic                     loc_sel_o;
  logic [MEM_WORD_SIZE-1:0] buffer_i;
  logic                     busy_o, done_o;
`ifdef CALC_CTRL_CNT_EN
  logic [ADDR_W:0]          word_cnt_o;
`endif

  calc_controller #(.ADDR_W(ADDR_W)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .start_i            (start_i),
    .read_start_addr_i  (read_start_addr_i),
    .read_end_addr_i    (read_end_addr_i),
    .write_start_addr_i (write_start_addr_i),
    .write_end_addr_i   (write_end_addr_i),
    .mem_re_o           (mem_re_o),
    .mem_we_o           (mem_we_o),
    .mem_addr_o         (mem_addr_o),
    .mem_rdata_i        (mem_rdata_i),
    .mem_wdata_o        (mem_wdata_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .loc_sel_o          (loc_sel_o),
    .buffer_i           (buffer_i),
    .busy_o             (busy_o),
`ifdef CALC_CTRL_CNT_EN
    .word_cnt_o         (word_cnt_o),
`endif
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] mem [0:1023];
  int checks = 0;
  int passes = 0;

  // Run-time observation state shared between the monitor and the job task
  bit   monEn = 1'b0;
  int   cyc, doneCnt, doneCyc, addIdx;
  bit   reDly1, reDly2;
  logic [ADDR_W-1:0] addrDly1, addrDly2;
  int   readLog[$];
  int   wrAddrLog[$];
  logic [63:0] wrDataLog[$];
  int   wrCycLog[$];

  // Reference results for the current job
  int   expRd[$];
  int   expWrA[$];
  logic [63:0] expWrD[$];

  typedef struct {
    int rs, re, ws, we;
    int expWrites, expReads, expLast;
  } vec_t;
  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory returns data one cycle after a read strobe, garbage otherwise
  always @(posedge clk_i) begin
    if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
    else          mem_rdata_i <= {$urandom, $urandom};
  end

  // Monitor: logs accesses and plays the external adder/result buffer
  always @(negedge clk_i) begin
    if (monEn) begin
      cyc++;
      if (mem_re_o && mem_we_o) checkOutput("re_we_exclusive", 64'(mem_we_o), 64'd0);
      if (mem_re_o) readLog.push_back(int'(mem_addr_o));
      if (mem_we_o) begin
        wrAddrLog.push_back(int'(mem_addr_o));
        wrDataLog.push_back(mem_wdata_o);
        wrCycLog.push_back(cyc);
      end
      if (done_o) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (reDly2) begin
        checkOutput("op_a", 64'(op_a_o), 64'(mem[addrDly2][31:0]));
        checkOutput("op_b", 64'(op_b_o), 64'(mem[addrDly2][63:32]));
        checkOutput("loc_sel", 64'(loc_sel_o), 64'(addIdx % 2));
        if (loc_sel_o) buffer_i[63:32] = op_a_o + op_b_o;
        else           buffer_i[31:0]  = op_a_o + op_b_o;
        addIdx++;
      end
      reDly2   = reDly1;
      addrDly2 = addrDly1;
      reDly1   = mem_re_o;
      addrDly1 = mem_addr_o;
    end
  end

  // Job-level model: output word k pairs reads 2k and 2k+1, clamped to the end
  // address; the run stops once the end address was read or the last slot written.
  task automatic modelJob(input int rs, input int re, input int ws, input int we);
    int a0, a1;
    logic [31:0] lo, hi;
    expRd.delete(); expWrA.delete(); expWrD.delete();
    if (rs <= re && ws <= we) begin
      for (int k = 0; k < 2048; k++) begin
        a0 = (rs + 2*k     > re) ? re : rs + 2*k;
        a1 = (rs + 2*k + 1 > re) ? re : rs + 2*k + 1;
        expRd.push_back(a0);
        expRd.push_back(a1);
        lo = mem[a0][31:0] + mem[a0][63:32];
        hi = mem[a1][31:0] + mem[a1][63:32];
        expWrA.push_back(ws + k);
        expWrD.push_back({hi, lo});
        if ((rs + 2*k + 1 >= re) || (ws + k == we)) break;
      end
    end
  endtask

  task automatic applyStimulus(input int rs, input int re, input int ws, input int we, input bit repulse);
    int waited;
    modelJob(rs, re, ws, we);
    @(negedge clk_i); #1;
    readLog.delete(); wrAddrLog.delete(); wrDataLog.delete(); wrCycLog.delete();
    doneCnt = 0; doneCyc = -1; cyc = 0; addIdx = 0;
    reDly1 = 1'b0; reDly2 = 1'b0;
    monEn = 1'b1;
    read_start_addr_i  = rs[ADDR_W-1:0];
    read_end_addr_i    = re[ADDR_W-1:0];
    write_start_addr_i = ws[ADDR_W-1:0];
    write_end_addr_i   = we[ADDR_W-1:0];
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    waited = 0;
    while (doneCnt == 0 && waited < 2000) begin
      @(posedge clk_i); #1;
      waited++;
      if (repulse && waited == 3) begin
        start_i            = 1'b1;
        read_start_addr_i  = 10'd500;
        read_end_addr_i    = 10'd900;
        write_start_addr_i = 10'd600;
        write_end_addr_i   = 10'd700;
      end
      if (repulse && waited == 5) start_i = 1'b0;
    end
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    monEn = 1'b0;

    checkOutput("done_pulse_count", 64'(doneCnt), 64'd1);
    checkOutput("idle_after_done", 64'(busy_o), 64'd0);
    checkOutput("read_count", 64'(readLog.size()), 64'(expRd.size()));
    for (int i = 0; i < expRd.size(); i++)
      checkOutput("read_addr", (i < readLog.size()) ? 64'(readLog[i]) : '1, 64'(expRd[i]));
    checkOutput("write_count", 64'(wrAddrLog.size()), 64'(expWrA.size()));
    for (int i = 0; i < expWrA.size(); i++) begin
      checkOutput("write_addr", (i < wrAddrLog.size()) ? 64'(wrAddrLog[i]) : '1, 64'(expWrA[i]));
      checkOutput("write_data", (i < wrDataLog.size()) ? wrDataLog[i] : '1, expWrD[i]);
    end
    if (expWrA.size() > 0) begin
      checkOutput("first_write_latency", (wrCycLog.size() > 0) ? 64'(wrCycLog[0]) : '1, 64'd7);
      for (int i = 1; i < wrCycLog.size(); i++)
        checkOutput("write_spacing", 64'(wrCycLog[i] - wrCycLog[i-1]), 64'd7);
    end else begin
      checkOutput("bad_range_done_latency", 64'(doneCyc), 64'd1);
    end
`ifdef CALC_CTRL_CNT_EN
    checkOutput("word_cnt", 64'(word_cnt_o), 64'(expWrA.size()));
`endif
  endtask

  initial begin
    int rs, re, ws, we;
    bit sawWe;

    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    buffer_i = '0;
    rst_i = 1'b1;
    start_i = 1'b0;
    read_start_addr_i = '0; read_end_addr_i = '0;
    write_start_addr_i = '0; write_end_addr_i = '0;

    repeat (3) @(negedge clk_i);
    checkOutput("reset_re", 64'(mem_re_o), 64'd0);
    checkOutput("reset_we", 64'(mem_we_o), 64'd0);
    checkOutput("reset_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    checkOutput("reset_ops", {op_b_o, op_a_o}, 64'd0);
    checkOutput("reset_loc_sel", 64'(loc_sel_o), 64'd0);
    rst_i = 1'b0;

    // Known operands, then a single-word job with hand-computed result
    mem[0] = 64'h00000002_00000001;
    mem[1] = 64'h00000010_00000005;
    applyStimulus(0, 1, 8, 8, 1'b0);
    checkOutput("basic_data", (wrDataLog.size() > 0) ? wrDataLog[0] : '1, 64'h00000015_00000003);

    // Odd operand count: the final word's halves come from the same address
    applyStimulus(0, 2, 8, 9, 1'b0);
    checkOutput("odd_halves_equal",
                (wrDataLog.size() > 1) ? 64'(wrDataLog[1][63:32]) : '1,
                (wrDataLog.size() > 1) ? 64'(wrDataLog[1][31:0]) : '0);

    vecs[0] = '{0,    1,    8,    8,    1, 2, 8};
    vecs[1] = '{0,    2,    8,    9,    2, 4, 9};
    vecs[2] = '{5,    3,    0,    4,    0, 0, 0};
    vecs[3] = '{0,    7,    8,    9,    2, 4, 9};
    vecs[4] = '{0,    7,    8,    15,   4, 8, 11};
    vecs[5] = '{3,    3,    20,   25,   1, 2, 20};
    vecs[6] = '{10,   20,   100,  100,  1, 2, 100};
    vecs[7] = '{0,    4,    2,    1,    0, 0, 0};
    vecs[8] = '{1020, 1023, 1022, 1023, 2, 4, 1023};
    vecs[9] = '{1023, 1023, 1023, 1023, 1, 2, 1023};
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].rs, vecs[v].re, vecs[v].ws, vecs[v].we, 1'b0);
      checkOutput("vec_writes", 64'(wrAddrLog.size()), 64'(vecs[v].expWrites));
      checkOutput("vec_reads", 64'(readLog.size()), 64'(vecs[v].expReads));
      if (wrAddrLog.size() > 0)
        checkOutput("vec_last_addr", 64'(wrAddrLog[wrAddrLog.size()-1]), 64'(vecs[v].expLast));
    end

    // Start pulsed again mid-run must not disturb the job in flight
    applyStimulus(0, 7, 8, 15, 1'b1);

    // Reset in the middle of a write
    @(negedge clk_i); #1;
    read_start_addr_i = 10'd0;  read_end_addr_i  = 10'd7;
    write_start_addr_i = 10'd8; write_end_addr_i = 10'd15;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    sawWe = 1'b0;
    for (int i = 0; i < 40 && !sawWe; i++) begin
      @(negedge clk_i);
      if (mem_we_o) sawWe = 1'b1;
    end
    checkOutput("write_reached_before_reset", 64'(sawWe), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("rst_we_drop", 64'(mem_we_o), 64'd0);
    checkOutput("rst_busy_drop", 64'(busy_o), 64'd0);
    checkOutput("rst_addr_clear", 64'(mem_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("no_resume_busy", 64'(busy_o), 64'd0);
    checkOutput("no_resume_re", 64'(mem_re_o), 64'd0);
    applyStimulus(2, 7, 30, 32, 1'b0);

    // Randomized jobs against the model
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
      rs = $urandom_range(0, 1015);
      re = rs + $urandom_range(0, 12);
      if (re > 1023) re = 1023;
      ws = $urandom_range(0, 1017);
      we = ws + $urandom_range(0, 6);
      if (we > 1023) we = 1023;
      if ($urandom_range(0, 7) == 0 && rs > 0) re = rs - 1;
      if ($urandom_range(0, 7) == 0 && ws > 0) we = ws - 1;
      applyStimulus(rs, re, ws, we, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
